// File: rtl/regfile_writeback_if.sv
// Bus between the DOF/EX stages and the write-back stage with its register file.
// The master side issues read addresses and execute results. The slave side
// returns read data, the stall request and the write-back status.
interface regfile_writeback_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // DOF read ports
  logic [AW-1:0] aa;
  logic [AW-1:0] ba;
  logic [DW-1:0] adata;
  logic [DW-1:0] bdata;

  // DOF issue information, used by the pending-write scoreboard
  logic          issue;
  logic          rw_d;
  logic [AW-1:0] da_d;

  // EX-stage result heading into write-back
  logic          rw_e;
  logic [AW-1:0] da_e;
  logic [1:0]    md_e;
  logic [DW-1:0] f_e;
  logic          nv_e;

  // Data-memory read data, valid during the WB cycle
  logic [DW-1:0] dmem_w;

  // Status returned to the pipeline
  logic          stall;
  logic          wb_rw;
  logic [AW-1:0] wb_da;
  logic [DW-1:0] wb_d;

  modport master (
    output aa, ba, issue, rw_d, da_d, rw_e, da_e, md_e, f_e, nv_e, dmem_w,
    input  adata, bdata, stall, wb_rw, wb_da, wb_d
  );

  modport slave (
    input  aa, ba, issue, rw_d, da_d, rw_e, da_e, md_e, f_e, nv_e, dmem_w,
    output adata, bdata, stall, wb_rw, wb_da, wb_d
  );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back stage combined with a 2**AW x DW register file.
// - An EX->WB pipeline register selects the write-back data.
// - The selected data is written into the file at the end of the WB cycle.
// - A same-cycle write is bypassed to both read ports.
// - A per-register pending-write counter raises stall while a source operand
//   is still in flight and the bypass cannot cover it.
module regfile_writeback #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int PCNTW = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_writeback_if.slave   bus
);

  localparam int NR = 1 << AW;
  localparam logic [PCNTW-1:0] CNT_MAX = {PCNTW{1'b1}};
  localparam logic [PCNTW-1:0] CNT_ONE = {{(PCNTW-1){1'b0}}, 1'b1};

  // Architectural state
  logic [DW-1:0]    regs_q [NR];
  logic [PCNTW-1:0] cnt_q  [NR];
  logic [PCNTW-1:0] cnt_d  [NR];

  // WB pipeline register
  logic             rw_wb_q;
  logic [AW-1:0]    da_wb_q;
  logic [1:0]       md_wb_q;
  logic [DW-1:0]    f_wb_q;
  logic             nv_wb_q;

  // Derived write-back values
  logic             wb_rw_s;
  logic [DW-1:0]    wb_d_s;
  logic             stall_a_s;
  logic             stall_b_s;
  logic [DW-1:0]    adata_s;
  logic [DW-1:0]    bdata_s;

  // Capture the EX-stage result every cycle; reset clears any in-flight write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rw_wb_q <= 1'b0;
      da_wb_q <= {AW{1'b0}};
      md_wb_q <= 2'b00;
      f_wb_q  <= {DW{1'b0}};
      nv_wb_q <= 1'b0;
    end else begin
      rw_wb_q <= bus.rw_e;
      da_wb_q <= bus.da_e;
      md_wb_q <= bus.md_e;
      f_wb_q  <= bus.f_e;
      nv_wb_q <= bus.nv_e;
    end
  end

  // Select the write-back data and qualify the strobe (R0 is never written)
  always_comb begin
    wb_rw_s = rw_wb_q && (da_wb_q != {AW{1'b0}});
    case (md_wb_q)
      2'b00:   wb_d_s = f_wb_q;
      2'b01:   wb_d_s = bus.dmem_w;
      2'b10:   wb_d_s = {{(DW-1){1'b0}}, nv_wb_q};
      2'b11:   wb_d_s = {DW{1'b0}};
      default: wb_d_s = {DW{1'b0}};
    endcase
  end

  // Register file write at the edge that ends the WB cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR; r++) begin
        regs_q[r] <= {DW{1'b0}};
      end
    end else if (wb_rw_s) begin
      regs_q[da_wb_q] <= wb_d_s;
    end else begin
      regs_q <= regs_q;
    end
  end

  // Read ports: R0 reads zero, a same-cycle write is bypassed to the reader
  always_comb begin
    if (bus.aa == {AW{1'b0}}) begin
      adata_s = {DW{1'b0}};
    end else if (wb_rw_s && (da_wb_q == bus.aa)) begin
      adata_s = wb_d_s;
    end else begin
      adata_s = regs_q[bus.aa];
    end
    if (bus.ba == {AW{1'b0}}) begin
      bdata_s = {DW{1'b0}};
    end else if (wb_rw_s && (da_wb_q == bus.ba)) begin
      bdata_s = wb_d_s;
    end else begin
      bdata_s = regs_q[bus.ba];
    end
  end

  // Pending-write counters.
  // - A counter increments on an accepted issue and decrements on write-back.
  // - Both in the same cycle leave it unchanged.
  // - It saturates at both ends.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = {PCNTW{1'b0}};
      end else begin
        if (bus.issue && !bus.stall && bus.rw_d && (bus.da_d == AW'(r)) &&
            !(wb_rw_s && (da_wb_q == AW'(r)))) begin
          if (cnt_q[r] != CNT_MAX) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
          end else begin
            cnt_d[r] = cnt_q[r];
          end
        end else if (wb_rw_s && (da_wb_q == AW'(r)) &&
                     !(bus.issue && !bus.stall && bus.rw_d && (bus.da_d == AW'(r)))) begin
          if (cnt_q[r] != {PCNTW{1'b0}}) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
          end else begin
            cnt_d[r] = cnt_q[r];
          end
        end else begin
          cnt_d[r] = cnt_q[r];
        end
      end
    end
  end

  // Pending-counter state; reset forgets every in-flight write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR; r++) begin
        cnt_q[r] <= {PCNTW{1'b0}};
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stall unless the source is clean or its last pending write retires now
  always_comb begin
    stall_a_s = (bus.aa != {AW{1'b0}}) && (cnt_q[bus.aa] != {PCNTW{1'b0}}) &&
                !(wb_rw_s && (da_wb_q == bus.aa) && (cnt_q[bus.aa] == CNT_ONE));
    stall_b_s = (bus.ba != {AW{1'b0}}) && (cnt_q[bus.ba] != {PCNTW{1'b0}}) &&
                !(wb_rw_s && (da_wb_q == bus.ba) && (cnt_q[bus.ba] == CNT_ONE));
  end

  assign bus.adata = adata_s;
  assign bus.bdata = bdata_s;
  assign bus.stall = stall_a_s || stall_b_s;
  assign bus.wb_rw = wb_rw_s;
  assign bus.wb_da = da_wb_q;
  assign bus.wb_d  = wb_d_s;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback.
// - A vector table covers the write-back mux, the bypass and R0.
// - Hand-written sequences cover the scoreboard, saturation and mid-flight reset.
module tb_regfile_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  regfile_writeback_if #(.DW(32), .AW(5)) bus_if ();

  regfile_writeback #(.DW(32), .AW(5), .PCNTW(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  typedef struct {
    logic        rw_e;
    logic [4:0]  da_e;
    logic [1:0]  md_e;
    logic [31:0] f_e;
    logic        nv_e;
    logic [31:0] dmem;
    logic [4:0]  aa;
    logic [4:0]  ba;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_wb_rw;
    logic [31:0] exp_wb_d;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge and return all inputs to idle
  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus_if.aa     = 5'd0;
    bus_if.ba     = 5'd0;
    bus_if.issue  = 1'b0;
    bus_if.rw_d   = 1'b0;
    bus_if.da_d   = 5'd0;
    bus_if.rw_e   = 1'b0;
    bus_if.da_e   = 5'd0;
    bus_if.md_e   = 2'b00;
    bus_if.f_e    = 32'd0;
    bus_if.nv_e   = 1'b0;
    bus_if.dmem_w = 32'd0;
  endtask

  task automatic issue_to(input logic [4:0] r);
    bus_if.issue = 1'b1;
    bus_if.rw_d  = 1'b1;
    bus_if.da_d  = r;
  endtask

  task automatic ex_write(input logic [4:0] r, input logic [31:0] f);
    bus_if.rw_e = 1'b1;
    bus_if.da_e = r;
    bus_if.md_e = 2'b00;
    bus_if.f_e  = f;
  endtask

  initial begin
    // Each row's outputs reflect the previous row's EX inputs (1-cycle WB latency)
    vecs[0] = '{1'b1, 5'd3, 2'b00, 32'hDEADBEEF, 1'b0, 32'h0,        5'd5, 5'd31,
                32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 5'd4, 2'b01, 32'h11111111, 1'b0, 32'h0,        5'd3, 5'd0,
                32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd0, 2'b00, 32'h00001234, 1'b0, 32'h0000CAFE, 5'd3, 5'd4,
                32'hDEADBEEF, 32'h0000CAFE, 1'b1, 32'h0000CAFE, 1'b0};
    vecs[3] = '{1'b1, 5'd5, 2'b10, 32'hFFFFFFFF, 1'b1, 32'hAAAA0000, 5'd4, 5'd0,
                32'h0000CAFE, 32'h0,        1'b0, 32'h00001234, 1'b0};
    vecs[4] = '{1'b1, 5'd6, 2'b11, 32'h55555555, 1'b0, 32'h0,        5'd5, 5'd0,
                32'h00000001, 32'h0,        1'b1, 32'h00000001, 1'b0};
    vecs[5] = '{1'b0, 5'd7, 2'b00, 32'h77777777, 1'b0, 32'h0,        5'd6, 5'd5,
                32'h0,        32'h00000001, 1'b1, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 5'd0, 2'b00, 32'h0,        1'b0, 32'h0,        5'd7, 5'd6,
                32'h0,        32'h0,        1'b0, 32'h77777777, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 2'b00, 32'h0,        1'b0, 32'h0,        5'd0, 5'd3,
                32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        1'b0};

    // Reset
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    bus_if.aa = 5'd5;
    bus_if.ba = 5'd31;
    #2;
    chk("reset_adata", bus_if.adata, 32'h0);
    chk("reset_bdata", bus_if.bdata, 32'h0);
    chk("reset_stall", {31'd0, bus_if.stall}, 32'h0);
    chk("reset_wb_rw", {31'd0, bus_if.wb_rw}, 32'h0);
    chk("reset_wb_d", bus_if.wb_d, 32'h0);
    chk("reset_wb_da", {27'd0, bus_if.wb_da}, 32'h0);

    // Table-driven write-back, bypass and R0 vectors
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus_if.rw_e   = vecs[i].rw_e;
      bus_if.da_e   = vecs[i].da_e;
      bus_if.md_e   = vecs[i].md_e;
      bus_if.f_e    = vecs[i].f_e;
      bus_if.nv_e   = vecs[i].nv_e;
      bus_if.dmem_w = vecs[i].dmem;
      bus_if.aa     = vecs[i].aa;
      bus_if.ba     = vecs[i].ba;
      #2;
      chk($sformatf("v%0d_adata", i), bus_if.adata, vecs[i].exp_a);
      chk($sformatf("v%0d_bdata", i), bus_if.bdata, vecs[i].exp_b);
      chk($sformatf("v%0d_wb_rw", i), {31'd0, bus_if.wb_rw}, {31'd0, vecs[i].exp_wb_rw});
      chk($sformatf("v%0d_wb_d", i), bus_if.wb_d, vecs[i].exp_wb_d);
      chk($sformatf("v%0d_stall", i), {31'd0, bus_if.stall}, {31'd0, vecs[i].exp_stall});
    end

    // Single pending write to R7: stall until its WB cycle, then bypass
    next_cycle();
    issue_to(5'd7);
    #2;
    chk("r7_issue_stall", {31'd0, bus_if.stall}, 32'h0);
    next_cycle();
    bus_if.aa = 5'd7;
    ex_write(5'd7, 32'hABCD0007);
    #2;
    chk("r7_ex_stall", {31'd0, bus_if.stall}, 32'h1);
    next_cycle();
    bus_if.aa = 5'd7;
    #2;
    chk("r7_wb_stall", {31'd0, bus_if.stall}, 32'h0);
    chk("r7_wb_bypass", bus_if.adata, 32'hABCD0007);
    chk("r7_wb_rw", {31'd0, bus_if.wb_rw}, 32'h1);
    next_cycle();
    bus_if.aa = 5'd7;
    #2;
    chk("r7_after_stall", {31'd0, bus_if.stall}, 32'h0);
    chk("r7_after_file", bus_if.adata, 32'hABCD0007);

    // Two writes in flight to R9: the first WB must not clear the stall
    next_cycle();
    issue_to(5'd9);
    next_cycle();
    issue_to(5'd9);
    #2;
    chk("r9_second_issue_stall", {31'd0, bus_if.stall}, 32'h0);
    next_cycle();
    bus_if.ba = 5'd9;
    ex_write(5'd9, 32'h09090001);
    #2;
    chk("r9_cnt2_stall", {31'd0, bus_if.stall}, 32'h1);
    next_cycle();
    bus_if.ba = 5'd9;
    ex_write(5'd9, 32'h09090002);
    #2;
    chk("r9_first_wb_stall", {31'd0, bus_if.stall}, 32'h1);
    chk("r9_first_wb_bdata", bus_if.bdata, 32'h09090001);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus_if.aa = 5'd9;
    #2;
    chk("r9_rst_stall", {31'd0, bus_if.stall}, 32'h0);
    chk("r9_rst_adata", bus_if.adata, 32'h0);
    chk("r9_rst_wb_rw", {31'd0, bus_if.wb_rw}, 32'h0);

    // Saturation: four issues to R10 leave the counter at 3, three WBs drain it
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      issue_to(5'd10);
    end
    next_cycle();
    bus_if.aa = 5'd10;
    ex_write(5'd10, 32'h0A0A0001);
    #2;
    chk("r10_sat_stall", {31'd0, bus_if.stall}, 32'h1);
    next_cycle();
    bus_if.aa = 5'd10;
    ex_write(5'd10, 32'h0A0A0002);
    #2;
    chk("r10_wb1_stall", {31'd0, bus_if.stall}, 32'h1);
    next_cycle();
    bus_if.aa = 5'd10;
    ex_write(5'd10, 32'h0A0A0003);
    #2;
    chk("r10_wb2_stall", {31'd0, bus_if.stall}, 32'h1);
    next_cycle();
    bus_if.aa = 5'd10;
    ex_write(5'd10, 32'h0A0A0004);
    #2;
    chk("r10_wb3_stall", {31'd0, bus_if.stall}, 32'h0);
    chk("r10_wb3_adata", bus_if.adata, 32'h0A0A0003);
    // Extra WB with no pending write: the counter must stay at zero
    next_cycle();
    bus_if.aa = 5'd10;
    #2;
    chk("r10_extra_wb_stall", {31'd0, bus_if.stall}, 32'h0);
    next_cycle();
    bus_if.aa = 5'd10;
    #2;
    chk("r10_floor_stall", {31'd0, bus_if.stall}, 32'h0);
    chk("r10_floor_adata", bus_if.adata, 32'h0A0A0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
